// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   DATA_W     : width of one serial data byte
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   BIT_IDX_W  : width of the data-bit index
//   state_t    : transmitter FSM states
package fifo_uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;
  localparam int BIT_IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Serial bit timer: a CLKS_PER_BIT down-counter.
// tick is high in the last cycle of each bit period; the counter reloads
// itself on tick, so consecutive bits need no further control.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the counter)
//   restart  : reload so the next cycle is the first of a fresh bit period
//   tick     : last cycle of the current bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO that feeds the transmitter.
// data_out is registered: it is valid the cycle after a read edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, din      : write strobe and data (ignored when full)
//   rd_en, data_out : read strobe (ignored when empty) and registered data
//   empty, full     : occupancy flags
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full apart from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        data_out <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream sync_fifo and sends
// them as 8N1 frames (LSB first, idle high).
// Per byte: READ pulses fifo_rd_en, LOAD captures fifo_data (valid one cycle
// after the read edge), then START/DATA/STOP each hold a level for
// CLKS_PER_BIT cycles. Back-to-back bytes leave a 2-cycle high gap.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tx_en      : permits fetching new bytes
//   fifo_empty : upstream empty flag
//   fifo_data  : upstream registered data_out
//   fifo_rd_en : upstream read strobe, one cycle per byte
//   tx         : registered serial line
//   busy       : high whenever the FSM is not IDLE
//   frame_cnt  : completed frames, wrapping
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t                 state;
  state_t                 state_next;
  logic                   tick;
  logic                   timer_restart;
  logic                   frame_done;
  logic                   fetch_ok;
  logic [DATA_W-1:0]      shift_q;
  logic [BIT_IDX_W-1:0]   bit_idx;

  // Only consulted in IDLE and at STOP exit.
  assign fetch_ok = tx_en && !fifo_empty;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (timer_restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    fifo_rd_en    = 1'b0;
    busy          = 1'b1;
    timer_restart = 1'b0;
    frame_done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fetch_ok) state_next = READ;
      end
      READ: begin
        fifo_rd_en = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        // Align the timer so START gets a full bit period.
        timer_restart = 1'b1;
        state_next    = START;
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick && (bit_idx == BIT_IDX_W'(DATA_W - 1))) state_next = STOP;
      end
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_next = fetch_ok ? READ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tx is registered: each transition edge loads the level of the bit that
  // the next state transmits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      shift_q   <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      case (state)
        LOAD: begin
          shift_q <= fifo_data;
          bit_idx <= '0;
          tx      <= 1'b0;
        end
        START: begin
          if (tick) begin
            tx      <= shift_q[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            // bit_idx wraps 7 -> 0 as DATA hands over to the stop bit.
            bit_idx <= bit_idx + BIT_IDX_W'(1);
            if (bit_idx == BIT_IDX_W'(DATA_W - 1)) begin
              tx <= 1'b1;
            end else begin
              tx <= shift_q[bit_idx + BIT_IDX_W'(1)];
            end
          end
        end
        default: begin
          tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with an upstream sync_fifo (depth 8).
// Stimulus pushes each byte written to the FIFO onto exp_q; an independent
// line monitor decodes 8N1 frames from tx and compares against exp_q.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk;
  logic       rst;
  logic       fifo_rst;
  logic       tx_en;
  logic       wr_en;
  logic [7:0] din;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_cmp;
  int n_err;

  logic [7:0] exp_q[$];
  logic [7:0] exp_frames;
  int         rd_cnt;
  int         since_rd;
  int         gap;
  bit         have_prev;
  bit         chk_gap;
  bit         mon_active;
  int         mon_cyc;
  bit         hold_err;
  logic       prev_tx;
  logic       bits [FRAME_BITS];

  sync_fifo #(.DEPTH(8), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .rst      (fifo_rst),
    .wr_en    (wr_en),
    .din      (din),
    .rd_en    (fifo_rd_en),
    .data_out (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes frames, checks bit hold times, start latency after
  // the read strobe, inter-frame gap, and compares bytes against exp_q.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      prev_tx    = 1'b1;
      since_rd   = 99;
      gap        = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        check("rd_on_empty", 32'(fifo_empty), 32'd0);
        since_rd = 0;
      end else if (since_rd < 99) begin
        since_rd++;
      end
      if (!mon_active) begin
        if (tx == 1'b0 && prev_tx == 1'b1) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
          hold_err   = 1'b0;
          check("start_latency", 32'(since_rd), 32'd2);
          if (chk_gap && have_prev) check("gap", 32'(gap), 32'd2);
        end else if (tx) begin
          gap++;
        end
      end
      if (mon_active) begin
        if (mon_cyc % CPB == 0) bits[mon_cyc / CPB] = tx;
        else if (tx !== bits[mon_cyc / CPB]) hold_err = 1'b1;
        if (mon_cyc == FRAME_CYC - 1) begin
          logic [7:0] got;
          for (int i = 0; i < 8; i++) got[i] = bits[i + 1];
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[FRAME_BITS - 1]), 32'd1);
          check("bit_hold", 32'(hold_err), 32'd0);
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 32'(got), 32'hFFFF_FFFF);
          end else begin
            check("frame_byte", 32'(got), 32'(exp_q.pop_front()));
          end
          exp_frames = exp_frames + 8'd1;
          have_prev  = 1'b1;
          gap        = 0;
          mon_active = 1'b0;
        end else begin
          mon_cyc++;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic push_byte(input logic [7:0] b, output bit ok);
    ok = !fifo_full;
    if (ok) begin
      wr_en = 1'b1;
      din   = b;
      exp_q.push_back(b);
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(fifo_empty && !busy && !mon_active) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || mon_active) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_frame_start(input int budget, input string name);
    int n = 0;
    while (!mon_active && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    bit ok;
    int rd0;
    int sent;
    int guard;
    n_cmp = 0; n_err = 0; rd_cnt = 0; exp_frames = 8'd0;
    have_prev = 1'b0; chk_gap = 1'b0; mon_active = 1'b0;
    rst = 1'b1; fifo_rst = 1'b1; tx_en = 1'b0; wr_en = 1'b0; din = 8'd0;

    // Reset state on the first edge with rst high.
    @(posedge clk); @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; fifo_rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Single byte 0xA5.
    rd0 = rd_cnt;
    push_byte(8'hA5, ok);
    tx_en = 1'b1;
    wait_drain(200, "a5");
    check("a5_frame_cnt", 32'(frame_cnt), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    check("a5_empty", 32'(fifo_empty), 32'd1);
    check("a5_rd_pulses", 32'(rd_cnt - rd0), 32'd1);

    // Full FIFO 0x01..0x08 sent back-to-back.
    tx_en = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), ok);
    check("fill_full", 32'(fifo_full), 32'd1);
    rd0 = rd_cnt; have_prev = 1'b0; chk_gap = 1'b1;
    tx_en = 1'b1;
    wait_drain(1000, "burst");
    chk_gap = 1'b0;
    check("burst_rd_pulses", 32'(rd_cnt - rd0), 32'd8);
    check("burst_frame_cnt", 32'(frame_cnt), 32'd9);
    check("burst_q_empty", 32'(exp_q.size()), 32'd0);

    // Random bytes with random tx_en toggling.
    for (int it = 0; it < 30; it++) begin
      int n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push_byte(8'($urandom), ok);
      tx_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 60)) @(posedge clk);
      #1;
    end
    tx_en = 1'b1;
    wait_drain(2000, "random");
    check("random_q_empty", 32'(exp_q.size()), 32'd0);
    check("random_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // tx_en low holds off reads; dropping it mid-frame lets that frame finish.
    tx_en = 1'b0;
    rd0 = rd_cnt;
    for (int k = 0; k < 3; k++) push_byte(8'($urandom), ok);
    repeat (100) @(posedge clk);
    #1;
    check("hold_no_rd", 32'(rd_cnt - rd0), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    wait_frame_start(20, "drop_start");
    repeat (12) @(posedge clk);
    #1;
    tx_en = 1'b0;
    wait_idle(100, "drop");
    check("drop_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_remaining", 32'(exp_q.size()), 32'd2);
    repeat (10) @(posedge clk);
    #1;
    check("drop_no_more_rd", 32'(rd_cnt - rd0), 32'd1);
    tx_en = 1'b1;
    wait_drain(500, "drop_rest");
    check("drop_rest_rd", 32'(rd_cnt - rd0), 32'd3);

    // Reset during DATA bit 3 aborts the frame; the next byte resumes cleanly.
    push_byte(8'h3C, ok);
    push_byte(8'($urandom), ok);
    tx_en = 1'b1;
    wait_frame_start(20, "abort_start");
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    exp_frames = 8'd0;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    wait_drain(500, "resume");
    check("resume_frame_cnt", 32'(frame_cnt), 32'd1);
    check("resume_q_empty", 32'(exp_q.size()), 32'd0);

    // frame_cnt wraps 0xFF -> 0x00 on the 256th frame since reset.
    sent = 0; guard = 0;
    while (sent < 254 && guard < 30000) begin
      push_byte(8'($urandom), ok);
      if (ok) sent++;
      else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    if (guard >= 30000) check("wrap_feed_timeout", 32'd1, 32'd0);
    wait_drain(2000, "wrap");
    check("wrap_ff", 32'(frame_cnt), 32'hFF);
    push_byte(8'($urandom), ok);
    wait_drain(200, "wrap_last");
    check("wrap_00", 32'(frame_cnt), 32'h00);
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the frame counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_en  input  1  permits fetching new bytes from the FIFO.
REQ-006 SHALL have port fifo_empty  input  1  empty flag of the upstream sync_fifo.
REQ-007 SHALL have port fifo_data  input  8  data_out of the upstream sync_fifo, valid the cycle after a read edge.
REQ-008 SHALL have port fifo_rd_en  output  1  read strobe to the sync_fifo rd_en.
REQ-009 SHALL have port tx  output  1  UART serial line: 8N1, LSB first, idle high, registered.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port frame_cnt  output  CNT_W  count of completed frames, wrapping.

Function
REQ-012 SHALL implement states IDLE, READ, LOAD, START, DATA, STOP.
REQ-013 IDLE -> READ SHALL occur at an edge sampling tx_en=1 and fifo_empty=0; otherwise the block SHALL stay in IDLE.
REQ-014 fifo_rd_en SHALL be high only during the READ state: exactly one cycle per byte.
REQ-015 READ -> LOAD SHALL be unconditional; LOAD SHALL capture fifo_data into the shift register and then go to START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive shift bits 0..7, each for CLKS_PER_BIT cycles.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, from entry to START until exit from STOP.
REQ-020 On STOP exit the block SHALL increment frame_cnt (mod 2^CNT_W).
REQ-021 On STOP exit the block SHALL go to READ if tx_en=1 and fifo_empty=0, else to IDLE.
REQ-022 With back-to-back bytes, tx SHALL stay high for exactly 2 cycles (READ and LOAD) between the stop bit and the next start bit.
REQ-023 The first start bit SHALL begin 2 edges after the IDLE edge that sampled a non-empty FIFO.
REQ-024 fifo_rd_en SHALL never be asserted in a cycle where the sampling decision saw fifo_empty=1; there SHALL be no read-on-empty.
REQ-025 fifo_empty and fifo_data SHALL be ignored outside the IDLE decision, the STOP-exit decision and the LOAD state.
REQ-026 Deasserting tx_en mid-frame SHALL let the current frame complete; no further read SHALL follow.
REQ-027 The bit-timer counter width SHALL be $clog2(CLKS_PER_BIT); the bit index SHALL be 3 bits and wrap 7 -> exit DATA.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set state=IDLE, tx=1, busy=0, fifo_rd_en=0, frame_cnt=0, and clear the shift register, bit index and bit timer.
REQ-029 Reset mid-frame SHALL abort the frame: tx=1 from the next edge, no frame_cnt increment, no read until after rst is released.
REQ-030 rst SHALL have priority over all other inputs.

Structure
REQ-031 Package fifo_uart_pkg SHALL hold the state enum, DATA_W=8, and FRAME_BITS=10.
REQ-032 The bit timing SHALL live in one sub-module, bit_timer: a CLKS_PER_BIT down-counter with a restart input and a tick output; all other logic SHALL stay in fifo_uart_tx.
REQ-033 The bench SHALL instantiate sync_fifo (depth 8) upstream, with fifo_rd_en -> rd_en, empty -> fifo_empty, and data_out -> fifo_data.

Verification (CLKS_PER_BIT=4)
REQ-034 Reset -> tx=1, busy=0, fifo_rd_en=0, frame_cnt=0 on the first edge after rst=1.
REQ-035 Write 0xA5, tx_en=1 -> one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 total); then frame_cnt=1, busy=0, FIFO empty.
REQ-036 Fill the FIFO with 0x01..0x08 (full=1), tx_en=1 -> 8 rd pulses, 8 frames decoded in order 0x01..0x08, 2-cycle high gaps, frame_cnt=8, no rd_en after empty.
REQ-037 FIFO holding 3 bytes with tx_en=0 -> no rd_en for 100 cycles; raise tx_en, then drop it during bit 2 of the first frame -> that frame completes, 2 bytes remain, busy=0.
REQ-038 rst pulsed during DATA bit 3 -> tx=1 the next cycle, frame_cnt=0, state IDLE; after release a non-empty FIFO resumes with a fresh frame.
REQ-039 CNT_W=8, 256 frames sent -> frame_cnt wraps 0xFF -> 0x00 on the 256th STOP exit.
